sqrt_seq_ctrl: RTL
==================

// Module: sqrt_seq_ctrl
// PURPOSE
//  Sequencer for the FP16 square-root datapath: accepts one operand per valid/ready transfer and strobes
//  classify -> normalize -> digit-recurrence -> round, one op in flight. Decodes normalize's
//  is_num/is_nan/is_pinf/is_ninf/sign/zero result to bypass the iteration stage for specials; result via valid/ready.
// PARAMETERS
//  ITERS  12  recurrence iterations per op (1..2**CNT_W)
//  CNT_W  4   width of iter_idx
//  WAIT_T 4   cycles WAIT_N tolerates without n_valid before abort
// PORTS
//  clk           in   1      clock; all state on rising edge
//  rst_n         in   1      reset, synchronous, active-low
//  in_valid      in   1      operand available
//  in_ready      out  1      controller idle; transfer = in_valid & in_ready
//  flush         in   1      synchronous abort to IDLE, any state
//  op_load       out  1      1-cycle pulse: datapath latches operand
//  cls_en        out  1      classifier enable
//  norm_en       out  1      drives normalize enable and s_valid
//  n_valid       in   1      normalize result valid
//  n_is_num/n_is_nan/n_is_pinf/n_is_ninf  in 1 each  normalize class flags
//  n_sign        in   1      normalize sign_out
//  n_zero        in   1      normalized mantissa == 0 with n_is_num
//  iter_start    out  1      first-iteration pulse (loads remainder)
//  iter_en       out  1      recurrence step enable
//  iter_idx      out  CNT_W  current iteration, 0..ITERS-1
//  rnd_en        out  1      rounding/pack stage enable
//  res_sel       out  3      000 computed, 001 qNaN, 010 +inf, 011 +0, 100 -0
//  out_valid     out  1      result valid; held until out_ready
//  out_ready     in   1      consumer accepts
//  err           out  1      1-cycle pulse on n_valid timeout
// BEHAVIOUR
//  States: IDLE, CLASS, NORM, WAIT_N, ITER, ROUND, DONE. One-hot or binary is implementer's choice.
//  Reset (rst_n=0 at edge): state IDLE, iter_idx=0, res_sel=000, all other outputs 0; in_ready=0 while rst_n=0.
//  IDLE: in_ready=1. Transfer -> op_load=1 same cycle, next CLASS. No transfer -> stay.
//  CLASS: cls_en=1 one cycle -> NORM.  NORM: norm_en=1 one cycle -> WAIT_N (guard counter cleared).
//  WAIT_N: on n_valid decode, priority order:
//   n_is_nan -> 001; n_is_pinf -> 010; n_is_ninf -> 001; n_is_num & n_zero -> 011 if !n_sign else 100;
//   n_is_num & n_sign -> 001; n_is_num -> ITER (res_sel=000). No flag set -> 001. Specials -> DONE.
//   No n_valid: guard++; at guard==WAIT_T-1 without n_valid -> err=1 one cycle, state IDLE, no result.
//  ITER: iter_en=1; iter_start=1 only when iter_idx==0; iter_idx increments per cycle;
//   at iter_idx==ITERS-1 -> ROUND, iter_idx cleared to 0 on exit. iter_idx never exceeds ITERS-1.
//  ROUND: rnd_en=1 one cycle -> DONE.
//  DONE: out_valid=1, res_sel stable; out_ready -> IDLE next cycle. No back-to-back accept in DONE cycle.
//  Latency (transfer cycle = 0): normal out_valid at cycle ITERS+5 (17 default); special at cycle 4.
//  flush: overrides every transition; next state IDLE, iter_idx=0, res_sel=000, pending result dropped;
//   flush in IDLE with in_valid: no transfer (in_ready=0 that cycle), op_load=0.
//  All strobes mutually exclusive; strobe outputs decoded from state register (glitch-free after edge).
//  res_sel/iter_idx registered; hold value except as stated.
// CONFIGURATION
//  SQRT_CTRL_PERF_EN defined: adds outputs perf_ops[15:0] (out_valid&out_ready count) and
//   perf_special[15:0] (specials completed); both wrap at 16'hFFFF->0, cleared by rst_n, not by flush.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Operand 1.0 (n_is_num, sign 0, zero 0), out_ready=1 -> op_load@0, iter_en cycles 4..15, rnd_en@16, out_valid@17, res_sel=000.
//  n_valid with n_is_num, n_sign=1, n_zero=0 -> out_valid@4, res_sel=001, iter_en never high.
//  n_zero=1, n_sign=1 -> res_sel=100; n_is_pinf -> 010; n_is_ninf -> 001; no ITER for any.
//  n_valid withheld -> err pulse @ cycle 3+WAIT_T-1, state IDLE, in_ready=1 next cycle, out_valid never.
//  flush at cycle 8 of ITER -> IDLE next cycle, iter_idx=0, no out_valid; new op then completes normally.
//  out_ready low 5 cycles in DONE -> out_valid/res_sel held, in_ready=0; rst_n=0 mid-ITER -> all outputs 0 next edge.

Source files
------------

// File: rtl/sqrt_seq_ctrl_if.sv
// rtl/sqrt_seq_ctrl_if.sv - operand/result handshake bundle for the FP16 sqrt sequencer
interface sqrt_seq_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] res_sel;

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  res_sel
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid,
        output res_sel
    );
endinterface

// File: rtl/sqrt_seq_ctrl.sv
// rtl/sqrt_seq_ctrl.sv - FP16 sqrt sequencer, optional perf counters under SQRT_CTRL_PERF_EN
module sqrt_seq_ctrl #(
    parameter int ITERS  = 12,
    parameter int CNT_W  = 4,
    parameter int WAIT_T = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    sqrt_seq_ctrl_if.slave   bus,
    input  logic             flush,
    output logic             op_load,
    output logic             cls_en,
    output logic             norm_en,
    input  logic             n_valid,
    input  logic             n_is_num,
    input  logic             n_is_nan,
    input  logic             n_is_pinf,
    input  logic             n_is_ninf,
    input  logic             n_sign,
    input  logic             n_zero,
    output logic             iter_start,
    output logic             iter_en,
    output logic [CNT_W-1:0] iter_idx,
    output logic             rnd_en,
    output logic             err
`ifdef SQRT_CTRL_PERF_EN
    ,
    output logic [15:0]      perf_ops,
    output logic [15:0]      perf_special
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLASS  = 3'd1,
        NORM   = 3'd2,
        WAIT_N = 3'd3,
        ITER   = 3'd4,
        ROUND  = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam int               GW         = (WAIT_T > 1) ? $clog2(WAIT_T) : 1;
    localparam logic [GW-1:0]    GUARD_LAST = GW'(WAIT_T - 1);
    localparam logic [CNT_W-1:0] IDX_LAST   = CNT_W'(ITERS - 1);

    localparam logic [2:0] SEL_COMP = 3'b000;
    localparam logic [2:0] SEL_QNAN = 3'b001;
    localparam logic [2:0] SEL_PINF = 3'b010;
    localparam logic [2:0] SEL_PZRO = 3'b011;
    localparam logic [2:0] SEL_NZRO = 3'b100;

    state_t        state;
    logic [GW-1:0] guard;
    logic [2:0]    dec_sel;
    logic          accept;
    logic          timeout;

    // Strobes decode straight from the state register; only the transfer and
    // timeout pulses also look at inputs, and both are masked by reset and flush.
    assign bus.in_ready  = rst_n & ~flush & (state == IDLE);
    assign accept        = bus.in_valid & bus.in_ready;
    assign op_load       = accept;
    assign cls_en        = (state == CLASS);
    assign norm_en       = (state == NORM);
    assign iter_en       = (state == ITER);
    assign iter_start    = (state == ITER) && (iter_idx == '0);
    assign rnd_en        = (state == ROUND);
    assign bus.out_valid = (state == DONE);
    assign timeout       = (state == WAIT_N) && !n_valid && (guard == GUARD_LAST);
    assign err           = rst_n & ~flush & timeout;

    // Class decode of the normalize result; anything unrecognised becomes qNaN.
    always_comb begin
        dec_sel = SEL_QNAN;
        if (n_is_nan)                  dec_sel = SEL_QNAN;
        else if (n_is_pinf)            dec_sel = SEL_PINF;
        else if (n_is_ninf)            dec_sel = SEL_QNAN;
        else if (n_is_num && n_zero)   dec_sel = n_sign ? SEL_NZRO : SEL_PZRO;
        else if (n_is_num && n_sign)   dec_sel = SEL_QNAN;
        else if (n_is_num)             dec_sel = SEL_COMP;
        else                           dec_sel = SEL_QNAN;
    end

    // Sequencer: one operation in flight, flush wins over every transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            guard       <= '0;
            iter_idx    <= '0;
            bus.res_sel <= SEL_COMP;
        end else if (flush) begin
            state       <= IDLE;
            guard       <= '0;
            iter_idx    <= '0;
            bus.res_sel <= SEL_COMP;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) state <= CLASS;
                end
                CLASS: begin
                    state <= NORM;
                end
                NORM: begin
                    guard <= '0;
                    state <= WAIT_N;
                end
                WAIT_N: begin
                    if (n_valid) begin
                        bus.res_sel <= dec_sel;
                        state       <= (dec_sel == SEL_COMP) ? ITER : DONE;
                    end else if (timeout) begin
                        state <= IDLE;
                    end else begin
                        guard <= guard + GW'(1);
                    end
                end
                ITER: begin
                    if (iter_idx == IDX_LAST) begin
                        iter_idx <= '0;
                        state    <= ROUND;
                    end else begin
                        iter_idx <= iter_idx + CNT_W'(1);
                    end
                end
                ROUND: begin
                    state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SQRT_CTRL_PERF_EN
    // Completed-result counters survive flush; they wrap naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_ops     <= '0;
            perf_special <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            perf_ops <= perf_ops + 16'd1;
            if (bus.res_sel != SEL_COMP) perf_special <= perf_special + 16'd1;
        end
    end
`endif

endmodule
